// File: rtl/int_div_sched.sv
// int_div_sched: queues DIVU/REMU requests, issues them one at a time to the shared divider,
// keeps a per-register pending scoreboard and re-registers write-back. Perf counters: INT_DIV_SCHED_PERF_EN.
//
// state | meaning
// IDLE  | divider free; pop FIFO head when non-empty and div_busy low
// ISSUE | div_req asserted for this single cycle
// ARM   | waiting for divider to raise div_busy
// WAIT  | waiting for divider to drop div_busy
module int_div_sched #(
  parameter int data_width    = 32,
  parameter int reg_sel_width = 5,
  parameter int queue_depth   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic                            is_rem,
  input  logic [data_width-1:0]           rs1,
  input  logic [data_width-1:0]           rs2,
  input  logic [reg_sel_width-1:0]        rs1_sel,
  input  logic [reg_sel_width-1:0]        rs2_sel,
  input  logic [reg_sel_width-1:0]        rd_sel,
  output logic                            busy,
  output logic                            div_req,
  output logic [data_width-1:0]           div_a,
  output logic [data_width-1:0]           div_b,
  output logic [reg_sel_width-1:0]        div_quot_sel,
  output logic [reg_sel_width-1:0]        div_mod_sel,
  input  logic                            div_busy,
  input  logic                            div_wr_req,
  input  logic [reg_sel_width-1:0]        div_wr_sel,
  input  logic [data_width-1:0]           div_wr_data,
  output logic                            rf_wr_req,
  output logic [reg_sel_width-1:0]        rf_wr_sel,
  output logic [data_width-1:0]           rf_wr_data,
  output logic [2**reg_sel_width-1:0]     pending
`ifdef INT_DIV_SCHED_PERF_EN
  ,
  output logic [15:0]                     perf_stall_cnt,
  output logic [15:0]                     perf_done_cnt
`endif
);

  localparam int ptr_w = $clog2(queue_depth);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ARM   = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]                   state, state_nxt;
  logic [ptr_w:0]               wr_ptr, rd_ptr;
  logic [data_width-1:0]        q_a   [queue_depth];
  logic [data_width-1:0]        q_b   [queue_depth];
  logic [reg_sel_width-1:0]     q_rd  [queue_depth];
  logic                         q_rem [queue_depth];
  logic                         full, empty, hazard, accept, pop;
  logic [2**reg_sel_width-1:0]  pending_nxt;
  logic [ptr_w-1:0]             wr_idx, rd_idx;

  assign wr_idx = wr_ptr[ptr_w-1:0];
  assign rd_idx = rd_ptr[ptr_w-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) && (wr_idx == rd_idx);

  // Register 0 is never tracked, so it can never cause a hazard.
  assign hazard = ((rs1_sel != '0) && pending[rs1_sel]) ||
                  ((rs2_sel != '0) && pending[rs2_sel]) ||
                  ((rd_sel  != '0) && pending[rd_sel]);
  assign busy    = req & (full | hazard);
  assign accept  = req & ~busy;
  assign pop     = (state == IDLE) && !empty && !div_busy;
  assign div_req = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (accept) begin
      q_a[wr_idx]   <= rs1;
      q_b[wr_idx]   <= rs2;
      q_rd[wr_idx]  <= rd_sel;
      q_rem[wr_idx] <= is_rem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = ARM;
      ARM:     if (div_busy) state_nxt = WAIT;
      WAIT:    if (!div_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_a        <= '0;
      div_b        <= '0;
      div_quot_sel <= '0;
      div_mod_sel  <= '0;
    end else if (pop) begin
      div_a        <= q_a[rd_idx];
      div_b        <= q_b[rd_idx];
      div_quot_sel <= q_rem[rd_idx] ? '0 : q_rd[rd_idx];
      div_mod_sel  <= q_rem[rd_idx] ? q_rd[rd_idx] : '0;
    end
  end

  // Clear before set: an accepted rd can never be the bit being cleared, since that would be a hazard.
  always_comb begin
    pending_nxt = pending;
    if (div_wr_req) pending_nxt[div_wr_sel] = 1'b0;
    if (accept && (rd_sel != '0)) pending_nxt[rd_sel] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr_req  <= 1'b0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_req <= div_wr_req;
      if (div_wr_req) begin
        rf_wr_sel  <= div_wr_sel;
        rf_wr_data <= div_wr_data;
      end
    end
  end

`ifdef INT_DIV_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_done_cnt  <= '0;
    end else begin
      if (busy && (perf_stall_cnt != 16'hFFFF))     perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (rf_wr_req && (perf_done_cnt != 16'hFFFF)) perf_done_cnt  <= perf_done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int_div_sched.sv
// Bench for int_div_sched: directed and random requests against a queue/scoreboard reference
// model, with a behavioural divider that answers each issue after a variable busy period.
module tb_int_div_sched;
  localparam int DW = 32, SW = 5, DEPTH = 4;

  logic clk, rst, req, is_rem, busy, div_req, div_busy, div_wr_req, rf_wr_req;
  logic [DW-1:0] rs1, rs2, div_a, div_b, div_wr_data, rf_wr_data;
  logic [SW-1:0] rs1_sel, rs2_sel, rd_sel, div_quot_sel, div_mod_sel, div_wr_sel, rf_wr_sel;
  logic [2**SW-1:0] pending;
`ifdef INT_DIV_SCHED_PERF_EN
  logic [15:0] perf_stall_cnt, perf_done_cnt;
`endif

  int_div_sched #(.data_width(DW), .reg_sel_width(SW), .queue_depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .is_rem(is_rem), .rs1(rs1), .rs2(rs2),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .busy(busy),
    .div_req(div_req), .div_a(div_a), .div_b(div_b),
    .div_quot_sel(div_quot_sel), .div_mod_sel(div_mod_sel), .div_busy(div_busy),
    .div_wr_req(div_wr_req), .div_wr_sel(div_wr_sel), .div_wr_data(div_wr_data),
    .rf_wr_req(rf_wr_req), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
    .pending(pending)
`ifdef INT_DIV_SCHED_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_done_cnt(perf_done_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] a, b; logic [4:0] rd, s1, s2; logic rem; } stim_t;
  typedef struct { logic [4:0] sel; logic [31:0] data; } wb_t;

  int total = 0, bad = 0;

  stim_t script[$];
  stim_t m_q[$];
  wb_t   m_wb[$];
  stim_t m_cur, h;
  bit    h_v, rand_en, m_act, m_hi, m_issue, m_rf_v;
  logic [31:0] m_pend, m_rf_data;
  logic [4:0]  m_rf_sel;
  int          d_cnt, lat_fix;
  logic [31:0] d_a, d_b;
  logic [4:0]  d_qs, d_ms;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] a, b, input logic [4:0] rd,
                               input logic rem, input logic [4:0] s1, s2);
    stim_t s;
    s.a = a; s.b = b; s.rd = rd; s.rem = rem; s.s1 = s1; s.s2 = s2;
    return s;
  endfunction

  function automatic stim_t rand_req();
    stim_t s;
    s.rd  = 5'($urandom_range(0, 7));
    s.rem = (s.rd != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    s.s1  = 5'($urandom_range(0, 7));
    s.s2  = 5'($urandom_range(0, 7));
    s.a   = $urandom;
    s.b   = $urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : 32'($urandom_range(1, 32'hFFFF));
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete(); m_wb.delete();
    m_cur = mk(0, 0, 0, 0, 0, 0);
    m_pend = '0; m_act = 0; m_hi = 0; m_issue = 0;
    m_rf_v = 0; m_rf_sel = '0; m_rf_data = '0;
    d_cnt = 0; div_busy = 0; div_wr_req = 0; div_wr_sel = '0; div_wr_data = '0;
    h_v = 0; script.delete();
  endtask

  function automatic bit model_idle();
    return !h_v && script.size() == 0 && m_q.size() == 0 && !m_act && d_cnt == 0 &&
           m_wb.size() == 0 && !div_wr_req && !m_rf_v;
  endfunction

  task automatic cycle();
    wb_t w;
    bit hz, m_busy, acc, pop, fin, arm;
    @(negedge clk);
    // observe outputs produced by the previous edge
    check("div_req", div_req, m_issue);
    check("div_a", div_a, m_cur.a);
    check("div_b", div_b, m_cur.b);
    check("div_quot_sel", div_quot_sel, m_cur.rem ? 5'd0 : m_cur.rd);
    check("div_mod_sel", div_mod_sel, m_cur.rem ? m_cur.rd : 5'd0);
    check("pending", pending, m_pend);
    check("rf_wr_req", rf_wr_req, m_rf_v);
    if (m_rf_v) begin
      check("rf_wr_sel", rf_wr_sel, m_rf_sel);
      check("rf_wr_data", rf_wr_data, m_rf_data);
      if (m_wb.size() == 0) check("wb_unexpected", rf_wr_req, 1'b0);
      else begin
        w = m_wb.pop_front();
        check("wb_ref_sel", rf_wr_sel, w.sel);
        check("wb_ref_data", rf_wr_data, w.data);
      end
    end
    // behavioural divider
    div_wr_req = 1'b0;
    if (d_cnt > 0) begin
      d_cnt--;
      if (d_cnt == 0) begin
        div_busy    = 1'b0;
        div_wr_req  = 1'b1;
        div_wr_sel  = d_qs | d_ms;
        div_wr_data = (d_ms != 0) ? d_a % d_b : d_a / d_b;
      end
    end
    if (div_req) begin
      d_a = div_a; d_b = div_b; d_qs = div_quot_sel; d_ms = div_mod_sel;
      d_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(2, 10));
      div_busy = 1'b1;
    end
    // request stimulus, held until accepted
    if (!h_v) begin
      if (script.size() > 0) begin h = script.pop_front(); h_v = 1; end
      else if (rand_en && $urandom_range(0, 99) < 45) begin h = rand_req(); h_v = 1; end
    end
    req = h_v;
    if (h_v) begin
      rs1 = h.a; rs2 = h.b; rd_sel = h.rd; is_rem = h.rem; rs1_sel = h.s1; rs2_sel = h.s2;
    end else begin
      rs1 = $urandom; rs2 = $urandom; rd_sel = 5'($urandom); is_rem = 1'($urandom);
      rs1_sel = 5'($urandom); rs2_sel = 5'($urandom);
    end
    #1;
    hz = (h.s1 != 0 && m_pend[h.s1]) || (h.s2 != 0 && m_pend[h.s2]) || (h.rd != 0 && m_pend[h.rd]);
    m_busy = h_v && (m_q.size() == DEPTH || hz);
    check("busy", busy, m_busy);
    // reference model of the coming edge, from pre-edge values
    acc = h_v && !m_busy;
    pop = !m_act && m_q.size() > 0 && !div_busy;
    fin = m_act && m_hi && !div_busy;
    arm = m_act && !m_issue && div_busy;
    if (fin) m_act = 0;
    else if (arm) m_hi = 1;
    m_issue = pop;
    if (pop) begin m_cur = m_q.pop_front(); m_act = 1; m_hi = 0; end
    if (div_wr_req) m_pend[div_wr_sel] = 1'b0;
    if (acc) begin
      m_q.push_back(h);
      w.sel = h.rd; w.data = h.rem ? h.a % h.b : h.a / h.b;
      m_wb.push_back(w);
      if (h.rd != 0) m_pend[h.rd] = 1'b1;
      h_v = 0;
    end
    m_rf_v = div_wr_req; m_rf_sel = div_wr_sel; m_rf_data = div_wr_data;
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n = 0;
    bit timed_out;
    while (!model_idle() && n < bound) begin cycle(); n++; end
    timed_out = !model_idle();
    check(tag, timed_out, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_div_req", div_req, 1'b0);
    check("rst_div_ab", {div_a, div_b}, 64'd0);
    check("rst_sels", {div_quot_sel, div_mod_sel}, 10'd0);
    check("rst_rf", {rf_wr_req, rf_wr_sel, rf_wr_data}, 38'd0);
    check("rst_pending", pending, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    bit reached;
    rst = 1'b0; req = 0; is_rem = 0; rs1 = 0; rs2 = 0; rs1_sel = 0; rs2_sel = 0; rd_sel = 0;
    rand_en = 0; lat_fix = 10;
    model_reset();
    apply_reset();

    script.push_back(mk(100, 7, 3, 0, 0, 0));
    run_until_idle("drain_divu", 200);
    script.push_back(mk(100, 7, 4, 1, 0, 0));
    run_until_idle("drain_remu", 200);
    for (int i = 1; i <= 6; i++) script.push_back(mk(32'(1000 * i + 3), 32'(i + 2), 5'(i), 1'(i % 2), 0, 0));
    run_until_idle("drain_burst", 400);
    script.push_back(mk(50, 5, 5, 0, 0, 0));
    script.push_back(mk(77, 9, 6, 0, 5, 0));
    script.push_back(mk(91, 4, 5, 1, 0, 0));
    script.push_back(mk(81, 3, 0, 0, 0, 0));
    run_until_idle("drain_hazard", 400);

    lat_fix = 0; rand_en = 1;
    for (int i = 0; i < 1500; i++) cycle();
    rand_en = 0;
    run_until_idle("drain_random", 400);

    lat_fix = 10;
    script.push_back(mk(10, 3, 1, 0, 0, 0));
    script.push_back(mk(20, 3, 2, 1, 0, 0));
    script.push_back(mk(30, 3, 3, 0, 0, 0));
    n = 0;
    while (!(m_act && m_hi && m_q.size() == 2) && n < 60) begin cycle(); n++; end
    reached = m_act && m_hi && m_q.size() == 2;
    check("reach_wait_2q", reached, 1'b1);
    apply_reset();
    script.push_back(mk(200, 9, 7, 1, 0, 0));
    run_until_idle("drain_after_rst", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
